assoc_lru_cache: RTL and testbench

- Parametrised, fully associative key/data store with true-LRU replacement and an explicit request/response handshake.
- Supports LOOKUP, WRITE, INVALIDATE and FLUSH operations, reports evicted entries, and tracks occupancy.
- Has a timed scan mode that steps through valid entries in index order for display/debug readout.
- Sits between a command source (switches/UART decoder) and the display/output path.

---
 rtl/assoc_lru_cache_if.sv | 44 ++++
 rtl/assoc_lru_cache.sv | 217 +++++++++++++++++++++
 tb/tb_assoc_lru_cache.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/assoc_lru_cache_if.sv
// Request/response, eviction, occupancy and scan signals of the associative LRU cache.
// The cache takes the slave modport; the command source takes the master modport.
interface assoc_lru_cache_if #(
  parameter int unsigned KEY_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned NUM_DATA_LOG2 = 3
);
  localparam int unsigned IdxW = (NUM_DATA_LOG2 > 0) ? NUM_DATA_LOG2 : 1;

  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [KEY_WIDTH-1:0]  req_key;
  logic [DATA_WIDTH-1:0] req_data;

  logic                  rsp_valid;
  logic                  rsp_hit;
  logic [DATA_WIDTH-1:0] rsp_data;

  logic                  evict_valid;
  logic [KEY_WIDTH-1:0]  evict_key;
  logic [DATA_WIDTH-1:0] evict_data;

  logic [NUM_DATA_LOG2:0] occupancy;

  logic                  scan_start;
  logic                  scan_valid;
  logic [IdxW-1:0]       scan_index;
  logic [KEY_WIDTH-1:0]  scan_key;
  logic [DATA_WIDTH-1:0] scan_data;
  logic                  scan_done;

  modport slave (
    input  req_valid, req_op, req_key, req_data, scan_start,
    output req_ready, rsp_valid, rsp_hit, rsp_data, evict_valid, evict_key, evict_data,
           occupancy, scan_valid, scan_index, scan_key, scan_data, scan_done
  );

  modport master (
    output req_valid, req_op, req_key, req_data, scan_start,
    input  req_ready, rsp_valid, rsp_hit, rsp_data, evict_valid, evict_key, evict_data,
           occupancy, scan_valid, scan_index, scan_key, scan_data, scan_done
  );
endinterface

// File: rtl/assoc_lru_cache.sv
// Fully associative key/data store with true-LRU replacement (age permutation),
// LOOKUP/WRITE/INVALIDATE/FLUSH requests and a timed scan of valid entries.
module assoc_lru_cache #(
  parameter int unsigned KEY_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned NUM_DATA_LOG2 = 3,
  parameter int unsigned SCAN_PERIOD   = 50000000
) (
  input  logic                    clk,
  input  logic                    async_reset,
  assoc_lru_cache_if.slave        bus
);
  localparam int unsigned NumData = 1 << NUM_DATA_LOG2;
  localparam int unsigned IdxW    = (NUM_DATA_LOG2 > 0) ? NUM_DATA_LOG2 : 1;
  localparam int unsigned OccW    = NUM_DATA_LOG2 + 1;
  localparam int unsigned TmrW    = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

  localparam logic [IdxW-1:0] AgeMru  = IdxW'(NumData - 1);
  localparam logic [IdxW-1:0] AgeOne  = IdxW'(1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(SCAN_PERIOD - 1);
  localparam logic [OccW-1:0] OccOne  = OccW'(1);

  typedef enum logic [1:0] {OpLookup, OpWrite, OpInval, OpFlush} op_e;
  typedef enum logic {StIdle, StScan} state_e;

  state_e                state_q;
  logic [NumData-1:0]    valid_q;
  logic [KEY_WIDTH-1:0]  key_q  [NumData];
  logic [DATA_WIDTH-1:0] data_q [NumData];
  logic [IdxW-1:0]       age_q  [NumData];
  logic [OccW-1:0]       occ_q;
  logic [TmrW-1:0]       tmr_q;

  logic                  rsp_valid_q, rsp_hit_q, evict_valid_q, scan_valid_q, scan_done_q;
  logic [DATA_WIDTH-1:0] rsp_data_q, evict_data_q, scan_data_q;
  logic [KEY_WIDTH-1:0]  evict_key_q, scan_key_q;
  logic [IdxW-1:0]       scan_idx_q;

  logic            hit_any, free_any, nxt_any;
  logic [IdxW-1:0] hit_idx, free_idx, lru_idx, first_idx, nxt_idx, victim_idx, tgt_idx;
  logic [IdxW-1:0] age_touch  [NumData];
  logic [IdxW-1:0] age_demote [NumData];

  // Descending walk so each encoder settles on the lowest matching index.
  always_comb begin
    hit_any   = 1'b0;
    hit_idx   = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    lru_idx   = '0;
    first_idx = '0;
    nxt_any   = 1'b0;
    nxt_idx   = '0;
    for (int i = NumData - 1; i >= 0; i--) begin
      if (valid_q[i] && (key_q[i] == bus.req_key)) begin
        hit_any = 1'b1;
        hit_idx = IdxW'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IdxW'(i);
      end
      if (age_q[i] == '0) lru_idx = IdxW'(i);
      if (valid_q[i]) first_idx = IdxW'(i);
      if (valid_q[i] && (IdxW'(i) > scan_idx_q)) begin
        nxt_any = 1'b1;
        nxt_idx = IdxW'(i);
      end
    end
  end

  assign victim_idx = free_any ? free_idx : lru_idx;
  assign tgt_idx    = ((bus.req_op == OpWrite) && !hit_any) ? victim_idx : hit_idx;

  always_comb begin
    for (int i = 0; i < NumData; i++) begin
      age_touch[i]  = age_q[i];
      age_demote[i] = age_q[i];
      if (IdxW'(i) == tgt_idx) begin
        age_touch[i]  = AgeMru;
        age_demote[i] = '0;
      end else begin
        if (age_q[i] > age_q[tgt_idx]) age_touch[i]  = age_q[i] - AgeOne;
        if (age_q[i] < age_q[tgt_idx]) age_demote[i] = age_q[i] + AgeOne;
      end
    end
  end

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      state_q       <= StIdle;
      valid_q       <= '0;
      for (int i = 0; i < NumData; i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
        age_q[i]  <= IdxW'(i);
      end
      occ_q         <= '0;
      tmr_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_hit_q     <= 1'b0;
      rsp_data_q    <= '0;
      evict_valid_q <= 1'b0;
      evict_key_q   <= '0;
      evict_data_q  <= '0;
      scan_valid_q  <= 1'b0;
      scan_idx_q    <= '0;
      scan_key_q    <= '0;
      scan_data_q   <= '0;
      scan_done_q   <= 1'b0;
    end else begin
      // Response and eviction fields only live for the single cycle after acceptance.
      rsp_valid_q   <= 1'b0;
      rsp_hit_q     <= 1'b0;
      rsp_data_q    <= '0;
      evict_valid_q <= 1'b0;
      evict_key_q   <= '0;
      evict_data_q  <= '0;
      scan_done_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            rsp_valid_q <= 1'b1;
            unique case (bus.req_op)
              OpLookup: begin
                if (hit_any) begin
                  age_q      <= age_touch;
                  rsp_hit_q  <= 1'b1;
                  rsp_data_q <= data_q[hit_idx];
                end
              end
              OpWrite: begin
                age_q <= age_touch;
                if (hit_any) begin
                  data_q[hit_idx] <= bus.req_data;
                  rsp_hit_q       <= 1'b1;
                  rsp_data_q      <= bus.req_data;
                end else begin
                  if (free_any) begin
                    occ_q <= occ_q + OccOne;
                  end else begin
                    evict_valid_q <= 1'b1;
                    evict_key_q   <= key_q[victim_idx];
                    evict_data_q  <= data_q[victim_idx];
                  end
                  key_q[victim_idx]   <= bus.req_key;
                  data_q[victim_idx]  <= bus.req_data;
                  valid_q[victim_idx] <= 1'b1;
                end
              end
              OpInval: begin
                if (hit_any) begin
                  valid_q[hit_idx] <= 1'b0;
                  age_q            <= age_demote;
                  occ_q            <= occ_q - OccOne;
                  rsp_hit_q        <= 1'b1;
                end
              end
              OpFlush: begin
                valid_q <= '0;
                occ_q   <= '0;
                for (int i = 0; i < NumData; i++) age_q[i] <= IdxW'(i);
              end
              default: ;
            endcase
          end else if (bus.scan_start) begin
            if (occ_q == '0) begin
              scan_done_q <= 1'b1;
            end else begin
              state_q      <= StScan;
              tmr_q        <= '0;
              scan_valid_q <= 1'b1;
              scan_idx_q   <= first_idx;
              scan_key_q   <= key_q[first_idx];
              scan_data_q  <= data_q[first_idx];
            end
          end
        end
        StScan: begin
          if (tmr_q == TmrLast) begin
            tmr_q <= '0;
            if (nxt_any) begin
              scan_idx_q  <= nxt_idx;
              scan_key_q  <= key_q[nxt_idx];
              scan_data_q <= data_q[nxt_idx];
            end else begin
              state_q      <= StIdle;
              scan_valid_q <= 1'b0;
              scan_done_q  <= 1'b1;
              scan_idx_q   <= '0;
              scan_key_q   <= '0;
              scan_data_q  <= '0;
            end
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gated by reset so the block never advertises readiness while held in reset.
  assign bus.req_ready   = (state_q == StIdle) && async_reset;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_hit     = rsp_hit_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.evict_valid = evict_valid_q;
  assign bus.evict_key   = evict_key_q;
  assign bus.evict_data  = evict_data_q;
  assign bus.occupancy   = occ_q;
  assign bus.scan_valid  = scan_valid_q;
  assign bus.scan_index  = scan_idx_q;
  assign bus.scan_key    = scan_key_q;
  assign bus.scan_data   = scan_data_q;
  assign bus.scan_done   = scan_done_q;
endmodule

// File: tb/tb_assoc_lru_cache.sv
// Scoreboard bench for assoc_lru_cache: directed requests and scans push expected
// responses into queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_assoc_lru_cache;
  localparam int unsigned KW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned LG = 3;
  localparam int unsigned SP = 4;

  localparam logic [1:0] OP_LOOKUP = 2'd0;
  localparam logic [1:0] OP_WRITE  = 2'd1;
  localparam logic [1:0] OP_INVAL  = 2'd2;
  localparam logic [1:0] OP_FLUSH  = 2'd3;

  logic clk = 1'b0;
  logic async_reset;
  always #5 clk = ~clk;

  assoc_lru_cache_if #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .NUM_DATA_LOG2(LG)) bus ();

  assoc_lru_cache #(
    .KEY_WIDTH(KW), .DATA_WIDTH(DW), .NUM_DATA_LOG2(LG), .SCAN_PERIOD(SP)
  ) dut (
    .clk(clk),
    .async_reset(async_reset),
    .bus(bus)
  );

  typedef struct packed {
    logic       hit;
    logic [7:0] data;
    logic       ev;
    logic [7:0] ev_key;
    logic [7:0] ev_data;
    logic [3:0] occ;
  } rsp_t;

  typedef struct packed {
    logic       done;
    logic [2:0] idx;
    logic [7:0] key;
    logic [7:0] data;
  } scan_t;

  rsp_t  rsp_q[$];
  scan_t scan_q[$];
  rsp_t  mon_r;
  scan_t mon_s;
  int    checks = 0;
  int    errors = 0;
  bit    scan_chk_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (async_reset === 1'b1) begin
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
          mon_r = rsp_q.pop_front();
          chk("rsp_hit", 32'(bus.rsp_hit), 32'(mon_r.hit));
          chk("rsp_data", 32'(bus.rsp_data), 32'(mon_r.data));
          chk("evict_valid", 32'(bus.evict_valid), 32'(mon_r.ev));
          if (mon_r.ev) begin
            chk("evict_key", 32'(bus.evict_key), 32'(mon_r.ev_key));
            chk("evict_data", 32'(bus.evict_data), 32'(mon_r.ev_data));
          end
          chk("occupancy", 32'(bus.occupancy), 32'(mon_r.occ));
        end
      end else begin
        chk("evict_without_rsp", 32'(bus.evict_valid), 32'd0);
      end
      if (scan_chk_en && (bus.scan_valid || bus.scan_done)) begin
        if (scan_q.size() == 0) begin
          chk("scan_unexpected", 32'({bus.scan_valid, bus.scan_done}), 32'd0);
        end else begin
          mon_s = scan_q.pop_front();
          chk("scan_done", 32'(bus.scan_done), 32'(mon_s.done));
          chk("scan_valid", 32'(bus.scan_valid), 32'(!mon_s.done));
          if (!mon_s.done) begin
            chk("scan_index", 32'(bus.scan_index), 32'(mon_s.idx));
            chk("scan_key", 32'(bus.scan_key), 32'(mon_s.key));
            chk("scan_data", 32'(bus.scan_data), 32'(mon_s.data));
            chk("req_ready_in_scan", 32'(bus.req_ready), 32'd0);
          end
        end
      end
    end
  end

  // Caller is always positioned just after a rising edge.
  task automatic req(input logic [1:0] op, input logic [7:0] key, input logic [7:0] data,
                     input logic hit, input logic [7:0] rdata, input logic ev,
                     input logic [7:0] ek, input logic [7:0] ed, input logic [3:0] occ);
    int n = 0;
    while (!bus.req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_key   = key;
    bus.req_data  = data;
    rsp_q.push_back('{hit: hit, data: rdata, ev: ev, ev_key: ek, ev_data: ed, occ: occ});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic scan_pulse();
    bus.scan_start = 1'b1;
    @(posedge clk); #1;
    bus.scan_start = 1'b0;
  endtask

  task automatic push_scan(input logic [2:0] idx, input logic [7:0] key, input logic [7:0] data);
    for (int c = 0; c < SP; c++) scan_q.push_back('{done: 1'b0, idx: idx, key: key, data: data});
  endtask

  task automatic drain();
    int n = 0;
    while ((rsp_q.size() != 0 || scan_q.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 32'(rsp_q.size() + scan_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [7:0] full_keys [8];
  logic [7:0] full_data [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    full_keys = '{8'h10, 8'h20, 8'h12, 8'h30, 8'h40, 8'h15, 8'h16, 8'h17};
    full_data = '{8'hA0, 8'hB0, 8'hCC, 8'hD0, 8'hE0, 8'hA5, 8'hA6, 8'hA7};
    async_reset    = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_key    = '0;
    bus.req_data   = '0;
    bus.scan_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    async_reset = 1'b1;
    #1;
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_occupancy", 32'(bus.occupancy), 32'd0);
    chk("reset_scan_valid", 32'(bus.scan_valid), 32'd0);
    chk("reset_scan_done", 32'(bus.scan_done), 32'd0);
    @(posedge clk); #1;

    // Fill: every slot free, so no evictions; entry i ends with age i.
    for (int i = 0; i < 8; i++)
      req(OP_WRITE, 8'(8'h10 + i), 8'(8'hA0 + i), 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 4'(i + 1));

    req(OP_LOOKUP, 8'h10, 8'h00, 1'b1, 8'hA0, 1'b0, 8'h00, 8'h00, 4'd8);
    req(OP_WRITE,  8'h20, 8'hB0, 1'b0, 8'h00, 1'b1, 8'h11, 8'hA1, 4'd8);
    req(OP_WRITE,  8'h12, 8'hCC, 1'b1, 8'hCC, 1'b0, 8'h00, 8'h00, 4'd8);
    req(OP_LOOKUP, 8'h12, 8'h00, 1'b1, 8'hCC, 1'b0, 8'h00, 8'h00, 4'd8);
    req(OP_INVAL,  8'h13, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 4'd7);
    req(OP_WRITE,  8'h30, 8'hD0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 4'd8);
    // LRU is now entry 4 (key 0x14).
    req(OP_WRITE,  8'h40, 8'hE0, 1'b0, 8'h00, 1'b1, 8'h14, 8'hA4, 4'd8);
    req(OP_LOOKUP, 8'h99, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 4'd8);
    drain();

    // Full scan shows key 0x30 landed at index 3.
    for (int i = 0; i < 8; i++) push_scan(3'(i), full_keys[i], full_data[i]);
    scan_q.push_back('{done: 1'b1, idx: 3'd0, key: 8'h00, data: 8'h00});
    scan_pulse();
    drain();

    // Request wins over a simultaneous scan_start.
    bus.scan_start = 1'b1;
    req(OP_LOOKUP, 8'h30, 8'h00, 1'b1, 8'hD0, 1'b0, 8'h00, 8'h00, 4'd8);
    bus.scan_start = 1'b0;
    drain();
    chk("req_ready_after_ignored_scan", 32'(bus.req_ready), 32'd1);

    req(OP_FLUSH, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 4'd0);
    drain();
    scan_q.push_back('{done: 1'b1, idx: 3'd0, key: 8'h00, data: 8'h00});
    scan_pulse();
    drain();

    // Leave only indices 1 and 5 valid.
    for (int i = 0; i < 6; i++)
      req(OP_WRITE, 8'(8'h50 + i), 8'(8'h60 + i), 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 4'(i + 1));
    req(OP_INVAL, 8'h50, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 4'd5);
    req(OP_INVAL, 8'h52, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 4'd4);
    req(OP_INVAL, 8'h53, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 4'd3);
    req(OP_INVAL, 8'h54, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 4'd2);
    req(OP_INVAL, 8'h54, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 4'd2);
    drain();
    push_scan(3'd1, 8'h51, 8'h61);
    push_scan(3'd5, 8'h55, 8'h65);
    scan_q.push_back('{done: 1'b1, idx: 3'd0, key: 8'h00, data: 8'h00});
    scan_pulse();
    drain();

    // Reset in the middle of a scan.
    scan_chk_en = 1'b0;
    scan_pulse();
    repeat (2) @(posedge clk);
    #2;
    chk("scan_active_before_reset", 32'(bus.scan_valid), 32'd1);
    async_reset = 1'b0;
    #1;
    chk("midscan_reset_scan_valid", 32'(bus.scan_valid), 32'd0);
    chk("midscan_reset_occupancy", 32'(bus.occupancy), 32'd0);
    chk("midscan_reset_scan_done", 32'(bus.scan_done), 32'd0);
    @(posedge clk); #1;
    async_reset = 1'b1;
    scan_chk_en = 1'b1;
    #1;
    chk("post_reset_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;

    req(OP_LOOKUP, 8'h51, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 4'd0);
    req(OP_WRITE,  8'h70, 8'h01, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 4'd1);
    req(OP_WRITE,  8'h71, 8'h02, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 4'd2);
    req(OP_LOOKUP, 8'h71, 8'h00, 1'b1, 8'h02, 1'b0, 8'h00, 8'h00, 4'd2);
    req(OP_FLUSH,  8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 4'd0);
    req(OP_LOOKUP, 8'h70, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 4'd0);
    req(OP_LOOKUP, 8'h55, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 4'd0);
    req(OP_INVAL,  8'h71, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 4'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
